// File: rtl/mosi_cmd_sequencer.sv
// Streams the MOSI command list out of command-RAM port B to the SPI engine,
// one word per valid/ready transfer, with optional looping and pass counting.
module mosi_cmd_sequencer #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop_enable,
  input  logic [ADDR_WIDTH-1:0] max_index,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [DATA_WIDTH-1:0] cmd_data,
  output logic                  cmd_valid,
  input  logic                  cmd_ready,
  output logic [ADDR_WIDTH-1:0] cmd_index,
  output logic [15:0]           loop_count,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_PRESENT
  } state_e;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   index_q, index_d;
  logic [ADDR_WIDTH-1:0]   max_q, max_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    valid_q, valid_d;
  logic [15:0]             loops_q, loops_d;
  logic                    pend_q, pend_d;
  logic                    done_q, done_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      index_q <= '0;
      max_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      loops_q <= '0;
      pend_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      max_q   <= max_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      loops_q <= loops_d;
      pend_q  <= pend_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    max_d   = max_q;
    data_d  = data_q;
    valid_d = valid_q;
    loops_d = loops_q;
    pend_d  = pend_q;
    done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          max_d   = max_index;
          index_d = '0;
          loops_d = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (stop) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          data_d  = ram_data;
          valid_d = 1'b1;
          state_d = S_PRESENT;
        end
      end
      S_PRESENT: begin
        // A stop arriving on the transfer edge itself terminates at that transfer.
        pend_d = pend_q | stop;
        if (valid_q && cmd_ready) begin
          valid_d = 1'b0;
          if (pend_q || stop) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (index_q < max_q) begin
            index_d = index_q + ADDR_ONE;
            state_d = S_FETCH;
          end else if (loop_enable) begin
            index_d = '0;
            loops_d = loops_q + 16'd1;
            state_d = S_FETCH;
          end else begin
            loops_d = loops_q + 16'd1;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) pend_d = 1'b0;
  end

  // RAM address and presented index advance together, so one register serves both.
  assign ram_addr   = index_q;
  assign cmd_index  = index_q;
  assign cmd_data   = data_q;
  assign cmd_valid  = valid_q;
  assign loop_count = loops_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_mosi_cmd_sequencer.sv
// Randomized directed bench for mosi_cmd_sequencer with a synchronous-read RAM
// model on port B and an expected-transfer queue built from the sequencing rules.
module tb_mosi_cmd_sequencer;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic        stop;
  logic        loop_enable;
  logic [9:0]  max_index;
  logic [9:0]  ram_addr;
  logic [15:0] ram_data;
  logic [15:0] cmd_data;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_index;
  logic [15:0] loop_count;
  logic        busy;
  logic        done;

  logic [15:0] mem [1024];

  int unsigned checks   = 0;
  int unsigned failures = 0;

  mosi_cmd_sequencer #(.ADDR_WIDTH(10), .DATA_WIDTH(16)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .stop       (stop),
    .loop_enable(loop_enable),
    .max_index  (max_index),
    .ram_addr   (ram_addr),
    .ram_data   (ram_data),
    .cmd_data   (cmd_data),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_index  (cmd_index),
    .loop_count (loop_count),
    .busy       (busy),
    .done       (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Port B without output register: data follows the address one edge later.
  always @(posedge clk) ram_data <= mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_ram_addr"},   {22'd0, ram_addr},   32'd0);
    chk({tag, "_cmd_data"},   {16'd0, cmd_data},   32'd0);
    chk({tag, "_cmd_valid"},  {31'd0, cmd_valid},  32'd0);
    chk({tag, "_cmd_index"},  {22'd0, cmd_index},  32'd0);
    chk({tag, "_loop_count"}, {16'd0, loop_count}, 32'd0);
    chk({tag, "_busy"},       {31'd0, busy},       32'd0);
    chk({tag, "_done"},       {31'd0, done},       32'd0);
  endtask

  // rmode 0: ready always high; 1: random ready; 2: ready low 5 cycles at index 1.
  // In loop mode the run is ended by a stop pulse while the last wanted word is presented.
  task automatic run(input string tag, input int unsigned mx, input bit lp,
                     input int unsigned n_xfer, input int unsigned rmode);
    int unsigned exp_idx [$];
    int unsigned exp_lc, got, cyc, first_valid, last_xfer, stall, budget, e;
    logic [15:0] pd;
    logic [9:0]  pi;
    bit pv, stopped, finished, r;

    for (int unsigned k = 0; k < n_xfer; k++) exp_idx.push_back(k % (mx + 1));
    exp_lc = lp ? (n_xfer - 1) / (mx + 1) : 1;
    got = 0; first_valid = 0; last_xfer = 0; stall = 0;
    pv = 1'b0; stopped = 1'b0; finished = 1'b0; pd = '0; pi = '0;
    budget = 40 * n_xfer + 50;

    max_index   = mx[9:0];
    loop_enable = lp;
    start       = 1'b1;
    @(negedge clk);
    start     = 1'b0;
    max_index = 10'($urandom);
    cyc = 1;

    while (!finished && cyc < budget) begin
      if (first_valid == 0 && cmd_valid) begin
        chk({tag, "_first_valid_latency"}, cyc, 32'd3);
        first_valid = cyc;
      end
      if (pv) begin
        chk({tag, "_hold_valid"}, {31'd0, cmd_valid}, 32'd1);
        chk({tag, "_hold_data"},  {16'd0, cmd_data},  {16'd0, pd});
        chk({tag, "_hold_index"}, {22'd0, cmd_index}, {22'd0, pi});
      end

      start = 1'b0;
      stop  = 1'b0;
      if (rmode == 0) r = 1'b1;
      else if (rmode == 1) r = 1'($urandom_range(0, 1));
      else if (cmd_valid && cmd_index == 10'd1 && stall < 5) begin
        r = 1'b0;
        stall++;
      end else r = 1'b1;
      if (lp && cmd_valid && got == n_xfer - 1 && !stopped) begin
        stop    = 1'b1;
        r       = 1'b0;
        stopped = 1'b1;
      end
      if (cmd_valid && $urandom_range(0, 7) == 0) start = 1'b1;
      cmd_ready = r;

      if (cmd_valid && r) begin
        e = exp_idx[got];
        chk({tag, "_xfer_index"}, {22'd0, cmd_index}, e);
        chk({tag, "_xfer_data"},  {16'd0, cmd_data},  {16'd0, mem[e]});
        if (rmode == 0 && !lp && got > 0) chk({tag, "_xfer_interval"}, cyc - last_xfer, 32'd3);
        last_xfer = cyc;
        got++;
        if (got == n_xfer) finished = 1'b1;
      end
      pv = cmd_valid && !r;
      pd = cmd_data;
      pi = cmd_index;
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    stop      = 1'b0;
    cmd_ready = 1'b0;

    chk({tag, "_transfers_completed"}, got, n_xfer);
    chk({tag, "_done_pulse"},  {31'd0, done},       32'd1);
    chk({tag, "_busy_low"},    {31'd0, busy},       32'd0);
    chk({tag, "_valid_low"},   {31'd0, cmd_valid},  32'd0);
    chk({tag, "_loop_count"},  {16'd0, loop_count}, exp_lc);
    @(negedge clk);
    chk({tag, "_done_single"}, {31'd0, done},       32'd0);
  endtask

  task automatic abort_run(input string tag, input int unsigned d);
    max_index   = 10'd5;
    loop_enable = 1'b0;
    start       = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int unsigned i = 1; i < d; i++) begin
      chk({tag, "_no_valid_pre"}, {31'd0, cmd_valid}, 32'd0);
      @(negedge clk);
    end
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk({tag, "_done"},     {31'd0, done},      32'd1);
    chk({tag, "_busy"},     {31'd0, busy},      32'd0);
    chk({tag, "_no_valid"}, {31'd0, cmd_valid}, 32'd0);
    @(negedge clk);
    chk({tag, "_done_single"}, {31'd0, done},      32'd0);
    chk({tag, "_stays_idle"},  {31'd0, busy},      32'd0);
    chk({tag, "_no_valid2"},   {31'd0, cmd_valid}, 32'd0);
  endtask

  initial begin
    int unsigned wait_cyc, mx, n;
    bit lp;

    reset_n = 1'b0; start = 1'b0; stop = 1'b0; loop_enable = 1'b0;
    max_index = '0; cmd_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) mem[i] = 16'hA000 + 16'(i);
    mem[1023] = 16'hBEEF;

    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);
    chk_idle_outputs("post_reset");

    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("idle_stop_busy", {31'd0, busy}, 32'd0);
    chk("idle_stop_done", {31'd0, done}, 32'd0);
    start = 1'b1; stop = 1'b1;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
    chk("start_stop_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("start_stop_busy2", {31'd0, busy}, 32'd0);
    chk("start_stop_done",  {31'd0, done}, 32'd0);

    run("single_pass", 3, 1'b0, 4, 0);
    run("backpressure", 3, 1'b0, 4, 2);
    run("loop_wrap", 2, 1'b1, 11, 1);
    abort_run("stop_fetch", 1);
    abort_run("stop_wait", 2);
    run("max_1023_wrap", 1023, 1'b1, 1026, 1);
    run("max0_loop", 0, 1'b1, 5, 1);
    run("max0_single", 0, 1'b0, 1, 0);

    for (int t = 0; t < 6; t++) begin
      mx = $urandom_range(0, 7);
      lp = 1'($urandom_range(0, 1));
      n  = lp ? $urandom_range(1, 20) : mx + 1;
      run("random", mx, lp, n, 1);
    end

    max_index = 10'd3; loop_enable = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc = 0;
    while (!cmd_valid && wait_cyc < 20) begin
      @(negedge clk);
      wait_cyc++;
    end
    chk("areset_reached_valid", {31'd0, cmd_valid}, 32'd1);
    #2 reset_n = 1'b0;
    #1 chk_idle_outputs("async_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run("after_reset", 3, 1'b0, 4, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
